// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

  localparam int unsigned LANE_W = 8;

  // Set bits mark address bits that must be zero for an in-range access.
  function automatic logic [31:0] oor_mask(input int unsigned depth_log2);
    return ~((32'd1 << (depth_log2 + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word array with per-byte write enables, synchronous write and combinational read.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_be,
  output logic [31:0]           o_rdata
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [Words];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][b*LANE_W +: LANE_W] <= i_wdata[b*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store port responder: one outstanding valid/ready request, wait states, error response.
// Defining DMEM_MMIO_EN maps a read-only free-running cycle counter at MMIO_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
`ifdef DMEM_MMIO_EN
  localparam logic MmioEn = 1'b1;
`else
  localparam logic MmioEn = 1'b0;
`endif

  dmem_state_e r_state, w_state_d;
  logic        r_live;
  logic [3:0]  r_cnt, w_cnt_d;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_err, w_err_d;

  logic        w_accept, w_access, w_mmio, w_bad, w_arr_we;
  logic [31:0] w_arr_rdata, w_cycle;

  // r_live keeps req_ready low until the first edge after reset release.
  assign req_ready = r_live && (r_state == StIdle);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = req_valid && req_ready;
  assign w_access = (r_state == StWait) && (r_cnt == 4'd0);

  // WAIT always spends one decode cycle plus WAIT_CYCLES before the access point.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StWait;
          w_cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_mmio   = MmioEn && (r_addr == MMIO_ADDR);
  assign w_bad    = (|r_addr[1:0]) || (|(r_addr & oor_mask(DEPTH_LOG2)));
  assign w_err_d  = w_bad && !w_mmio;
  assign w_arr_we = w_access && r_we && !w_bad && !w_mmio;

  always_comb begin
    w_rdata_d = 32'd0;
    if (!r_we && !w_err_d) begin
      w_rdata_d = w_mmio ? w_cycle : w_arr_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_live  <= 1'b0;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_access) begin
        r_rdata <= w_rdata_d;
        r_err   <= w_err_d;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = 32'd0;
`endif

  dmem_word_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_idx   (r_addr[DEPTH_LOG2+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic against a word-array model.
module tb_dmem_responder;

  localparam int unsigned DEPTH_LOG2  = 6;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned WORDS       = 1 << DEPTH_LOG2;
  localparam logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mem [WORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MMIO_ADDR   (MMIO_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: aligned, in-range accesses touch mem[addr/4]; anything else is an error.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
    int unsigned idx;
    rd = 32'd0;
    er = (addr % 4 != 0) || (addr >= 4 * WORDS);
    if (er) return;
    idx = addr / 4;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end
    end else begin
      rd = mem[idx];
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input logic chk,
                     input logic [31:0] exp_rd, input logic exp_err,
                     output logic [31:0] rd, output int acc);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 50);
    check("latency", lat, WAIT_CYCLES + 1);
    rd = rsp_rdata;
    if (chk) begin
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      if (chk) begin
        check("hold_rdata", rsp_rdata, exp_rd);
        check("hold_err", rsp_err, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("valid_drop", rsp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] rd,
                     output logic er);
    int acc;
    logic [31:0] got;
    model(we, addr, wdata, be, rd, er);
    txn(we, addr, wdata, be, hold, 1'b1, rd, er, got, acc);
  endtask

  initial begin
    logic [31:0] rd, rd2, a;
    logic        er;
    int          acc1, acc2, k;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    reset = 1'b1;
    #1;
    check("ready_before_edge", req_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_release", req_ready, 1);

    for (int i = 0; i < int'(WORDS); i++) begin
      run(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);
    end

    // Full-word write then read back.
    run(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    run(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rw_deadbeef", rd, 32'hDEAD_BEEF);

    // Byte-lane merge.
    run(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
    run(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    run(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    check("lane_merge", rd, 32'h11BB_33DD);

    // Errors: misaligned read, out-of-range write, neighbour untouched.
    run(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er);
    check("misalign_err", er, 1);
    run(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("oor_err", er, 1);
    run(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er);
    run(1'b1, 32'h24, 32'h1234_5678, 4'h0, 0, rd, er);
    run(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er);

    // Backpressure on the response.
    run(1'b0, 32'h10, 32'h0, 4'hF, 4, rd, er);

    for (int t = 0; t < 120; t++) begin
      k = $urandom_range(0, 9);
      if (k == 0) a = 32'($urandom_range(0, WORDS - 1) * 4) | 32'($urandom_range(1, 3));
      else if (k == 1) a = ($urandom & 32'hFFFF_FF00) | 32'h100;
      else a = 32'($urandom_range(0, WORDS - 1) * 4);
      run(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
    end

    // Reset during WAIT discards the pending write and produces no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'h55;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_accepted", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rst_valid", rsp_valid, 0);
    check("abort_rst_ready", req_ready, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_hold_valid", rsp_valid, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_post_valid", rsp_valid, 0);
    end
    run(1'b0, 32'h8, 32'h0, 4'hF, 0, rd, er);

`ifdef DMEM_MMIO_EN
    txn(1'b0, MMIO_ADDR, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b0, rd, acc1);
    check("mmio_err0_a", rsp_err, 0);
    while (cyc < acc1 + 8) @(negedge clk);
    txn(1'b0, MMIO_ADDR, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0, rd2, acc2);
    check("mmio_err0_b", rsp_err, 0);
    check("mmio_delta", rd2 - rd, 32'd10);
`else
    acc1 = 0;
    acc2 = 0;
    run(1'b0, MMIO_ADDR, 32'h0, 4'hF, 0, rd, er);
    check("mmio_disabled_err", rsp_err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
